// File: rtl/mul_writeback_pkg.sv
// Shared types and widths for the multiplier writeback stage.
// Holds the FSM encoding and default data/address widths.
package mul_writeback_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;
  localparam int PROD_W     = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WR_LO = 2'b01,
    WR_HI = 2'b10
  } state_t;

  function automatic logic [DATA_W-1:0] lo_byte(
    input logic [PROD_W-1:0] v
  );
    return v[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] hi_byte(
    input logic [PROD_W-1:0] v
  );
    return v[PROD_W-1:DATA_W];
  endfunction

endpackage

// File: rtl/mul_writeback_if.sv
// Product handshake plus register-file write port of the
// multiplier writeback stage.
interface mul_writeback_if #(
  parameter int DATA_W     = mul_writeback_pkg::DATA_W,
  parameter int REG_ADDR_W = mul_writeback_pkg::REG_ADDR_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [2*DATA_W-1:0]   product;
  logic [REG_ADDR_W-1:0] dest_lo;
  logic [REG_ADDR_W-1:0] dest_hi;
  logic                  acc_en;
  logic                  acc_clr;
  logic                  write_enable;
  logic [REG_ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0]     write_data;
  logic                  busy;
  logic                  overflow;

  modport master (
    output in_valid,
    output product,
    output dest_lo,
    output dest_hi,
    output acc_en,
    output acc_clr,
    input  in_ready,
    input  write_enable,
    input  write_reg,
    input  write_data,
    input  busy,
    input  overflow
  );

  modport slave (
    input  in_valid,
    input  product,
    input  dest_lo,
    input  dest_hi,
    input  acc_en,
    input  acc_clr,
    output in_ready,
    output write_enable,
    output write_reg,
    output write_data,
    output busy,
    output overflow
  );

endinterface

// File: rtl/mul_wb_acc.sv
// Product accumulator: register, wide adder and sticky
// carry-out flag for MAC results.
module mul_wb_acc #(
  parameter int PROD_W = mul_writeback_pkg::PROD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic              acc_en,
  input  logic              acc_clr,
  input  logic [PROD_W-1:0] product,
  output logic [PROD_W:0]   sum,
  output logic              overflow
);

  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] base;

  assign base = acc_clr ? '0 : acc;
  assign sum  = {1'b0, base} + {1'b0, product};

  // A plain MUL with acc_clr still clears so the next MAC starts at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      if (acc_en) begin
        acc <= sum[PROD_W-1:0];
        if (sum[PROD_W]) overflow <= 1'b1;
      end else if (acc_clr) begin
        acc <= '0;
      end
    end
  end

endmodule

// File: rtl/mul_writeback.sv
// Splits 16-bit MUL/MAC results into two byte writes
// through the single register-file write port.
module mul_writeback #(
  parameter int DATA_W     = mul_writeback_pkg::DATA_W,
  parameter int REG_ADDR_W = mul_writeback_pkg::REG_ADDR_W
) (
  input logic          clk,
  input logic          reset,
  mul_writeback_if.slave wb
);

  import mul_writeback_pkg::*;

  localparam int PW = 2 * DATA_W;

  state_t                state;
  state_t                state_nx;
  logic [PW-1:0]         data_q;
  logic [REG_ADDR_W-1:0] dest_lo_q;
  logic [REG_ADDR_W-1:0] dest_hi_q;
  logic                  ready;
  logic                  accept;
  logic [PW:0]           sum;
  logic                  ovf;
  logic                  we;
  logic [REG_ADDR_W-1:0] wreg;
  logic [DATA_W-1:0]     wdata;

  assign ready  = !reset && (state != WR_LO);
  assign accept = wb.in_valid && ready;

  mul_wb_acc #(
    .PROD_W (PW)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .accept   (accept),
    .acc_en   (wb.acc_en),
    .acc_clr  (wb.acc_clr),
    .product  (wb.product),
    .sum      (sum),
    .overflow (ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      data_q    <= '0;
      dest_lo_q <= '0;
      dest_hi_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        dest_lo_q <= wb.dest_lo;
        dest_hi_q <= wb.dest_hi;
        data_q    <= wb.acc_en ? sum[PW-1:0]
                               : wb.product;
      end
    end
  end

  // WR_HI re-accepts so back-to-back products leave no bubble
  always_comb begin
    state_nx = state;
    we       = 1'b0;
    wreg     = '0;
    wdata    = '0;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = WR_LO;
      end
      WR_LO: begin
        state_nx = WR_HI;
        we       = 1'b1;
        wreg     = dest_lo_q;
        wdata    = data_q[DATA_W-1:0];
      end
      WR_HI: begin
        state_nx = accept ? WR_LO : IDLE;
        we       = 1'b1;
        wreg     = dest_hi_q;
        wdata    = data_q[PW-1:DATA_W];
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign wb.in_ready     = ready;
  assign wb.write_enable = we;
  assign wb.write_reg    = wreg;
  assign wb.write_data   = wdata;
  assign wb.busy         = (state != IDLE);
  assign wb.overflow     = ovf;

endmodule

// File: doc/mul_writeback.md
Name: mul_writeback

Overview:
- Downstream stage of the 8x8 Dadda multiplier in the 8-bit single-cycle processor.
- Accepts the 16-bit product over a valid/ready handshake and optionally accumulates it into a 16-bit accumulator.
- Serialises the result into two 8-bit register-file writes: low byte first, then high byte.
- Lets MUL/MAC results reach the 8-bit register file through its single write port.

Parameters:
- DATA_W, 8: register-file data width; product width is 2*DATA_W.
- REG_ADDR_W, 3: register-file address width (8 registers).

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- IN_VALID  input  1  product and controls valid this cycle.
- IN_READY  output  1  block can accept a product this cycle.
- PRODUCT  input  2*DATA_W  multiplier output Y.
- DEST_LO  input  REG_ADDR_W  destination register for the low byte.
- DEST_HI  input  REG_ADDR_W  destination register for the high byte.
- ACC_EN  input  1  add PRODUCT to the accumulator and write the sum.
- ACC_CLR  input  1  treat the accumulator as zero before this accept.
- WRITEENABLE  output  1  register-file write strobe.
- WRITEREG  output  REG_ADDR_W  register-file write address.
- WRITEDATA  output  DATA_W  register-file write data.
- BUSY  output  1  a write sequence is in progress (state != IDLE).
- OVERFLOW  output  1  sticky flag: accumulate carry-out.

Behaviour:
- Clocking and reset: one clock, CLK. RESET is synchronous and active-high; it is sampled only on the CLK rising edge.
- Reset state, effective on the next edge:
  - state=IDLE; accumulator=0; OVERFLOW=0; data and destination holding registers=0.
  - WRITEENABLE=0, WRITEREG=0, WRITEDATA=0, BUSY=0, IN_READY=0 while RESET is high.
- FSM states: IDLE, WR_LO, WR_HI.
- Outputs are Moore outputs from registered state and holding registers:
  - IDLE: WRITEENABLE=0, WRITEREG=0, WRITEDATA=0.
  - WR_LO: WRITEENABLE=1, WRITEREG=dest_lo_q, WRITEDATA=data_q[7:0].
  - WR_HI: WRITEENABLE=1, WRITEREG=dest_hi_q, WRITEDATA=data_q[15:8].
- IN_READY=1 in IDLE and WR_HI, 0 in WR_LO and during RESET.
- Accept: the accept event is IN_VALID & IN_READY at a rising edge. On accept:
  - Capture DEST_LO and DEST_HI.
  - Capture data_q = ACC_EN ? sum[15:0] : PRODUCT, where base = ACC_CLR ? 0 : acc and sum = base + PRODUCT (17-bit).
  - If ACC_EN: acc <= sum[15:0]; if sum[16]=1, OVERFLOW <= 1 (sticky until RESET).
  - If !ACC_EN and ACC_CLR: acc <= 0.
  - If !ACC_EN and !ACC_CLR: acc unchanged.
- Transitions:
  - IDLE: accept -> WR_LO; otherwise stay in IDLE.
  - WR_LO -> WR_HI unconditionally.
  - WR_HI: accept -> WR_LO (back-to-back, no bubble); otherwise -> IDLE.
- Latency: accept at edge N gives the low-byte write visible in cycle N+1 and the high-byte write in cycle N+2. Sustained throughput is one product per 2 cycles.
- Stall: IN_VALID during WR_LO is not accepted. The upstream stage holds PRODUCT and the controls stable until it sees IN_READY.
- DEST_LO==DEST_HI: both writes are issued; the register ends up holding the high byte.
- Arithmetic wraps modulo 2^16. There is no saturation.
- Reset mid-sequence: pending writes are dropped, no write after the reset edge, the accumulator is cleared.
- Inputs are ignored while RESET is high.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, WR_LO=2'b01, WR_HI=2'b10;
  - DATA_W and REG_ADDR_W defaults;
  - PROD_W = 2*DATA_W.
- One natural sub-module, mul_wb_acc: the accumulator register, 17-bit adder and sticky OVERFLOW. Its inputs are accept, ACC_EN, ACC_CLR and PRODUCT; its outputs are sum and OVERFLOW.
- The FSM and output muxing stay in mul_writeback.

Test Plan:
- Basic write, no accumulate: RESET for 2 cycles, then PRODUCT=16'd30 (5*6), DEST_LO=1, DEST_HI=2, ACC_EN=0, valid for 1 cycle.
  - Cycle N+1: WE=1, WRITEREG=1, WRITEDATA=8'h1E.
  - Cycle N+2: WE=1, WRITEREG=2, WRITEDATA=8'h00.
  - Cycle N+3: WE=0, BUSY=0.
- Back-to-back: 8'hFF*8'hFF=16'hFE01 to R3/R4, IN_VALID held high with 16'h0100 to R5/R6 queued next.
  - Writes in order: R3=01, R4=FE, R5=00, R6=01 on consecutive cycles.
  - IN_READY=0 during each WR_LO.
- Accumulate with overflow: ACC_EN=1, ACC_CLR=1, PRODUCT=16'hFFFF, then ACC_EN=1, ACC_CLR=0, PRODUCT=16'h0002.
  - Writes: FF, FF, then 01, 00.
  - OVERFLOW=1 after the second accept and stays high until RESET.
- ACC_CLR without ACC_EN: accumulate 16'h0010, then ACC_EN=0, ACC_CLR=1, PRODUCT=16'h1234, then ACC_EN=1, PRODUCT=16'h0001.
  - Second product writes 34, 12.
  - Third product writes 01, 00, proving the accumulator was cleared.
- Reset mid-sequence: assert RESET in the WR_LO cycle.
  - The next cycle has WE=0, no WR_HI write, state=IDLE, OVERFLOW=0.
  - A following ACC_EN=1, PRODUCT=16'h0003 writes 03, 00.
- Same destination: DEST_LO=DEST_HI=7, PRODUCT=16'hABCD.
  - Writes R7=CD, then R7=AB.
  - The bench's register-file model reads R7=8'hAB afterwards.
